pixel_write_queue: RTL and testbench
====================================

PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8, setting the number of queued pixel writes; it must be a power of two ≥2.
REQ-002 The block SHALL provide port Clck, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL provide port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL provide port paint_x_co, input, `SCR_WIDTH_BITS (8): upstream painter x coordinate.
REQ-005 The block SHALL provide port paint_y_co, input, `SCR_HEIGHT_BITS (7): upstream painter y coordinate.
REQ-006 The block SHALL provide port color, input, `COLOR_SIZE (3): upstream painter colour.
REQ-007 The block SHALL provide port print_enable, input, 1 bit: upstream write level, held high for several cycles per pixel.
REQ-008 The block SHALL provide port vga_ready, input, 1 bit: the VGA memory write port can accept a write this cycle.
REQ-009 The block SHALL provide port vga_x, output, `SCR_WIDTH_BITS: write address x.
REQ-010 The block SHALL provide port vga_y, output, `SCR_HEIGHT_BITS: write address y.
REQ-011 The block SHALL provide port vga_colour, output, `COLOR_SIZE: write data.
REQ-012 The block SHALL provide port vga_plot, output, 1 bit: single-cycle write strobe.
REQ-013 The block SHALL provide ports full and empty, outputs, 1 bit each: queue occupancy flags.
REQ-014 The block SHALL provide port overflow, output, 1 bit: sticky flag that a pixel was lost.

Function
REQ-015 Edge detection: a register en_d SHALL sample print_enable every cycle; a capture occurs on an edge where print_enable=1 and en_d=0. Exactly one capture per high pulse, whatever the pulse length.
REQ-016 On a capture, {paint_x_co, paint_y_co, color} as sampled on that edge SHALL be written at the write pointer, if accepted.
REQ-017 A capture SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge; otherwise it is discarded and overflow is set to 1.
REQ-018 count SHALL be $clog2(DEPTH)+1 bits wide; full=(count==DEPTH) and empty=(count==0), both combinational from count.
REQ-019 The read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
REQ-020 Drain FSM: states IDLE (vga_plot=0) and PLOT (vga_plot=1). The FSM goes to PLOT on any edge where empty=0 and vga_ready=1, and to IDLE otherwise.
REQ-021 Pop: on an edge entering or remaining in PLOT, vga_x/vga_y/vga_colour SHALL load the head entry and the read pointer advances; back-to-back pops SHALL give consecutive one-cycle strobes.
REQ-022 Outside a pop, vga_x/vga_y/vga_colour SHALL hold their last value.
REQ-023 A simultaneous push and pop SHALL leave count unchanged. A push into an empty queue is not poppable until the following edge, so minimum latency is 2 edges from the capture edge to vga_plot high.
REQ-024 If vga_ready=0, entries SHALL stay queued and no strobe is issued; order is strictly FIFO.

Reset
REQ-025 When Reset=1 on an edge, count, both pointers, en_d, vga_plot, vga_x, vga_y, vga_colour and overflow SHALL become 0, and the FSM SHALL become IDLE.
REQ-026 Reset SHALL override any concurrent capture or pop, and queued entries are discarded. Storage contents need not be cleared.
REQ-027 If print_enable is already high when Reset releases, en_d=0 SHALL cause one capture on the first edge after release.

Configuration
REQ-028 When the macro PIXEL_CLIP_EN is defined, a capture with x≥`SCR_WIDTH or y≥`SCR_HEIGHT SHALL be silently dropped: not queued, and overflow is unchanged.
REQ-029 When PIXEL_CLIP_EN is undefined, all captures SHALL be queued without a bounds check.

Structure
REQ-030 `SCR_WIDTH_BITS, `SCR_HEIGHT_BITS, `COLOR_SIZE, `SCR_WIDTH, `SCR_HEIGHT and a new `PIXEL_ENTRY_BITS (their width sum) SHALL live in header.v.
REQ-031 Entry storage SHALL be the sub-module pixel_queue_mem: a DEPTH×`PIXEL_ENTRY_BITS register array with synchronous write and asynchronous read. Pointer, count and FSM logic stay in pixel_write_queue.

Verification
REQ-032 Stimulus: vga_ready=1; print_enable high for 4 cycles with x=5, y=7, color=3'b010. Response: exactly one vga_plot pulse, with vga_x=5, vga_y=7, vga_colour=2, exactly 2 edges after the capture edge.
REQ-033 Stimulus: vga_ready=0; 8 pulses with x=0..7. Response: full=1 and overflow=0. A 9th pulse sets overflow=1. Then raising vga_ready gives 8 consecutive strobes with x=0..7, after which empty=1.
REQ-034 Stimulus: the queue is full and vga_ready=1, and a capture lands on the same edge as a pop. Response: the capture is accepted, count stays 8, and overflow stays 0.
REQ-035 Stimulus: Reset=1 asserted mid-drain with 3 entries queued. Response: on the next edge vga_plot=0, empty=1 and overflow=0, and no further strobes occur.
REQ-036 Stimulus: a pulse with x=200, y=10, once with PIXEL_CLIP_EN defined and once without. Response: with the macro, no strobe occurs and empty stays 1; without it, one strobe occurs with vga_x=200.

Source files
------------

// File: rtl/pixel_write_queue_pkg.sv
// ---------------------------------------------------------------------------
// pixel_write_queue_pkg
// Shared types for the pixel write queue: drain FSM state, the packed pixel
// entry and an on-screen test used when clipping is built in.
// The geometry defines mirror header.v (same guarded values), so the package
// compiles whether or not header.v has already been read.
// ---------------------------------------------------------------------------
`ifndef SCR_WIDTH_BITS
`define SCR_WIDTH_BITS 8
`endif
`ifndef SCR_HEIGHT_BITS
`define SCR_HEIGHT_BITS 7
`endif
`ifndef COLOR_SIZE
`define COLOR_SIZE 3
`endif
`ifndef SCR_WIDTH
`define SCR_WIDTH 160
`endif
`ifndef SCR_HEIGHT
`define SCR_HEIGHT 120
`endif
`ifndef PIXEL_ENTRY_BITS
`define PIXEL_ENTRY_BITS (`SCR_WIDTH_BITS + `SCR_HEIGHT_BITS + `COLOR_SIZE)
`endif

package pixel_write_queue_pkg;

   localparam int X_W     = `SCR_WIDTH_BITS;
   localparam int Y_W     = `SCR_HEIGHT_BITS;
   localparam int C_W     = `COLOR_SIZE;
   localparam int ENTRY_W = `PIXEL_ENTRY_BITS;

   localparam int SCR_W_PIX = `SCR_WIDTH;
   localparam int SCR_H_PIX = `SCR_HEIGHT;

   localparam logic [X_W-1:0] X_LIMIT = X_W'(SCR_W_PIX);
   localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(SCR_H_PIX);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLOT = 1'b1
   } drain_state_e;

   // Field order matches the {x, y, colour} packing written to storage.
   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] c;
   } pixel_t;

   function automatic logic pixel_on_screen(input pixel_t p);
      return (p.x < X_LIMIT) && (p.y < Y_LIMIT);
   endfunction

endpackage

// File: rtl/header.v
// ---------------------------------------------------------------------------
// header.v
// Screen geometry and pixel-entry widths shared by the pixel write queue and
// the code around it. Every define is guarded so this file and the copy in
// pixel_write_queue_pkg.sv can be read in either order without redefinition.
// ---------------------------------------------------------------------------
`ifndef SCR_WIDTH_BITS
`define SCR_WIDTH_BITS 8
`endif
`ifndef SCR_HEIGHT_BITS
`define SCR_HEIGHT_BITS 7
`endif
`ifndef COLOR_SIZE
`define COLOR_SIZE 3
`endif
`ifndef SCR_WIDTH
`define SCR_WIDTH 160
`endif
`ifndef SCR_HEIGHT
`define SCR_HEIGHT 120
`endif
`ifndef PIXEL_ENTRY_BITS
`define PIXEL_ENTRY_BITS (`SCR_WIDTH_BITS + `SCR_HEIGHT_BITS + `COLOR_SIZE)
`endif

// File: rtl/pixel_write_queue_mem.sv
// ---------------------------------------------------------------------------
// pixel_queue_mem
// Entry storage for the pixel write queue: DEPTH x WIDTH register array,
// synchronous write, asynchronous (combinational) read. No reset: stale
// contents are never observable because the owner tracks occupancy.
//
// Ports
//   clk_i    : clock, write occurs on rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module pixel_queue_mem
   import pixel_write_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_write_queue.sv
// ---------------------------------------------------------------------------
// pixel_write_queue
// Decouples an upstream painter from the VGA memory write port. Each rising
// edge of print_enable captures one {x, y, colour} pixel into a FIFO; a
// two-state drain FSM pops one entry per cycle whenever the queue is
// non-empty and vga_ready is high, presenting it with a one-cycle vga_plot
// strobe. A capture that finds the queue full (and no pop on that edge) is
// lost and sets the sticky overflow flag.
//
// Build option
//   PIXEL_CLIP_EN : when defined, captures outside the SCR_WIDTH x SCR_HEIGHT
//                   screen are dropped silently (not queued, no overflow).
//
// Ports
//   Clck         : clock, rising edge
//   Reset        : synchronous, active-high
//   paint_x_co   : painter x coordinate
//   paint_y_co   : painter y coordinate
//   color        : painter colour
//   print_enable : painter write level (one capture per high pulse)
//   vga_ready    : VGA write port can accept a write this cycle
//   vga_x/vga_y  : write address, held between pops
//   vga_colour   : write data, held between pops
//   vga_plot     : one-cycle write strobe per popped entry
//   full/empty   : queue occupancy flags
//   overflow     : sticky, a pixel was lost to a full queue
// ---------------------------------------------------------------------------
module pixel_write_queue
   import pixel_write_queue_pkg::*;
#(
   parameter int DEPTH = 8   // power of two, >= 2
) (
   input  logic                        Clck,
   input  logic                        Reset,
   input  logic [`SCR_WIDTH_BITS-1:0]  paint_x_co,
   input  logic [`SCR_HEIGHT_BITS-1:0] paint_y_co,
   input  logic [`COLOR_SIZE-1:0]      color,
   input  logic                        print_enable,
   input  logic                        vga_ready,
   output logic [`SCR_WIDTH_BITS-1:0]  vga_x,
   output logic [`SCR_HEIGHT_BITS-1:0] vga_y,
   output logic [`COLOR_SIZE-1:0]      vga_colour,
   output logic                        vga_plot,
   output logic                        full,
   output logic                        empty,
   output logic                        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Previous-cycle print_enable for rising-edge capture.
   logic en_d;

   logic [AW-1:0] wptr_q,  wptr_d;
   logic [AW-1:0] rptr_q,  rptr_d;
   logic [CW-1:0] count_q, count_d;
   drain_state_e  state_q, state_d;
   pixel_t        out_q,   out_d;
   logic          ovf_q,   ovf_d;

   pixel_t             cap_pix;
   pixel_t             head_pix;
   logic [ENTRY_W-1:0] head_raw;
   logic               capture;
   logic               in_range;
   logic               pop;
   logic               push;

   assign cap_pix = '{x: paint_x_co, y: paint_y_co, c: color};
   assign capture = print_enable & ~en_d;

`ifdef PIXEL_CLIP_EN
   assign in_range = pixel_on_screen(cap_pix);
`else
   assign in_range = 1'b1;
`endif

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // Drain FSM: PLOT for every cycle that pops, IDLE otherwise.
   always_comb begin
      state_d = ST_IDLE;
      if (!empty && vga_ready) begin
         state_d = ST_PLOT;
      end
   end

   assign pop = (state_d == ST_PLOT);

   // A full queue still accepts a capture when the same edge frees a slot.
   assign push = capture & in_range & (~full | pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      out_d   = out_q;
      count_d = count_q;
      ovf_d   = ovf_q | (capture & in_range & ~push);
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
         out_d  = head_pix;
      end
      // Simultaneous push and pop leave the count unchanged.
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clck) begin
      if (Reset) begin
         en_d    <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= ST_IDLE;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         en_d    <= print_enable;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         state_q <= state_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

   pixel_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_mem (
      .clk_i   (Clck),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (cap_pix),
      .raddr_i (rptr_q),
      .rdata_o (head_raw)
   );

   assign head_pix = pixel_t'(head_raw);

   assign vga_plot   = (state_q == ST_PLOT);
   assign vga_x      = out_q.x;
   assign vga_y      = out_q.y;
   assign vga_colour = out_q.c;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_queue
// Scoreboarded bench for pixel_write_queue. A reference model follows the
// queue rules with a plain SV queue on each rising edge and pushes every
// pixel it expects to be written into a scoreboard; a separate monitor on
// the falling edge pops the scoreboard on each vga_plot and also checks the
// flags and held outputs against the model.
// ---------------------------------------------------------------------------
module tb_pixel_write_queue;
   import pixel_write_queue_pkg::*;

   localparam int DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [X_W-1:0] x   = '0;
   logic [Y_W-1:0] y   = '0;
   logic [C_W-1:0] c   = '0;
   logic           pe  = 1'b0;
   logic           rdy = 1'b0;

   logic [X_W-1:0] vga_x;
   logic [Y_W-1:0] vga_y;
   logic [C_W-1:0] vga_colour;
   logic           vga_plot, full, empty, overflow;

   int n_cmp = 0;
   int n_bad = 0;

   pixel_write_queue #(.DEPTH(DEPTH)) dut (
      .Clck         (clk),
      .Reset        (rst),
      .paint_x_co   (x),
      .paint_y_co   (y),
      .color        (c),
      .print_enable (pe),
      .vga_ready    (rdy),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   pixel_t mq[$];       // pixels held in the queue
   pixel_t sb[$];       // scoreboard: pixels expected on the next strobe
   bit     m_prev = 0;
   bit     m_ovf  = 0;
   bit     m_plot = 0;
   pixel_t m_last = '0;
   int     cyc    = 0;
   int     m_cap_cyc = -1;

   function automatic bit visible(input pixel_t p);
`ifdef PIXEL_CLIP_EN
      return (int'(p.x) < SCR_W_PIX) && (int'(p.y) < SCR_H_PIX);
`else
      return (p.x == p.x);
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            mq.delete();
            sb.delete();
            m_prev = 0;
            m_ovf  = 0;
            m_plot = 0;
            m_last = '0;
         end else begin
            bit     cap_now;
            bit     pop_now;
            pixel_t p;
            cap_now = pe && !m_prev;
            m_prev  = pe;
            p       = '{x: x, y: y, c: c};
            pop_now = (mq.size() != 0) && rdy;
            if (pop_now) begin
               m_last = mq.pop_front();
               sb.push_back(m_last);
            end
            m_plot = pop_now;
            if (cap_now) begin
               m_cap_cyc = cyc;
               if (visible(p)) begin
                  if (mq.size() < DEPTH) mq.push_back(p);
                  else m_ovf = 1;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit mon_en   = 0;
   int n_strobe = 0;
   int run      = 0;
   int max_run  = 0;
   int plot_cyc = -1;
   bit prev_plot = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("plot", int'(vga_plot), int'(m_plot));
            if (vga_plot) begin
               n_strobe++;
               run++;
               if (run > max_run) max_run = run;
               if (!prev_plot) plot_cyc = cyc;
               if (sb.size() == 0) begin
                  chk("sb_nonempty", 0, 1);
               end else begin
                  pixel_t e;
                  e = sb.pop_front();
                  chk("wr_x", int'(vga_x), int'(e.x));
                  chk("wr_y", int'(vga_y), int'(e.y));
                  chk("wr_c", int'(vga_colour), int'(e.c));
               end
            end else begin
               run = 0;
               chk("hold_x", int'(vga_x), int'(m_last.x));
               chk("hold_y", int'(vga_y), int'(m_last.y));
               chk("hold_c", int'(vga_colour), int'(m_last.c));
            end
            prev_plot = vga_plot;
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("overflow", int'(overflow), int'(m_ovf));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse(input int px, input int py, input int pc, input int len, input int gap);
      @(negedge clk);
      x  = X_W'(px);
      y  = Y_W'(py);
      c  = C_W'(pc);
      pe = 1'b1;
      repeat (len) @(negedge clk);
      pe = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int s0;
      int ok;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_plot", int'(vga_plot), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_x", int'(vga_x), 0);
      mon_en = 1;
      rst = 1'b0;

      // Single long pulse: one strobe, two edges after the capture edge
      rdy = 1'b1;
      s0 = n_strobe;
      plot_cyc = -1;
      pulse(5, 7, 2, 4, 6);
      chk("single_strobes", n_strobe - s0, 1);
      chk("single_latency_edges", plot_cyc + 1 - m_cap_cyc, 2);
      chk("single_x", int'(vga_x), 5);
      chk("single_c", int'(vga_colour), 2);

      // Fill with the port stalled, overflow on the ninth, then drain
      rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) pulse(i, 3, i, 2, 1);
      chk("fill_full", int'(full), 1);
      chk("fill_ovf", int'(overflow), 0);
      pulse(99, 1, 1, 2, 1);
      chk("ninth_ovf", int'(overflow), 1);
      s0 = n_strobe;
      max_run = 0;
      @(negedge clk);
      rdy = 1'b1;
      repeat (DEPTH + 3) @(negedge clk);
      chk("drain_strobes", n_strobe - s0, DEPTH);
      chk("drain_run", max_run, DEPTH);
      chk("drain_empty", int'(empty), 1);

      // Full queue: capture on the same edge as a pop is accepted
      do_reset(2);
      rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) pulse(20 + i, i, 7 - i, 1, 1);
      chk("pre_full", int'(full), 1);
      @(negedge clk);
      rdy = 1'b1;
      x = 8'd77; y = 7'd33; c = 3'd5; pe = 1'b1;
      @(negedge clk);
      chk("simul_full", int'(full), 1);
      chk("simul_ovf", int'(overflow), 0);
      pe = 1'b0;
      repeat (DEPTH + 4) @(negedge clk);
      chk("simul_empty", int'(empty), 1);

      // Reset in the middle of a drain
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) pulse(40 + i, 2, 1, 1, 1);
      rdy = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_plot", int'(vga_plot), 0);
      chk("rst_mid_empty", int'(empty), 1);
      chk("rst_mid_ovf", int'(overflow), 0);
      rst = 1'b0;
      s0 = n_strobe;
      repeat (6) @(negedge clk);
      chk("rst_mid_no_strobe", n_strobe - s0, 0);

      // Off-screen pixel
      s0 = n_strobe;
      pulse(200, 10, 4, 2, 6);
`ifdef PIXEL_CLIP_EN
      chk("clip_strobes", n_strobe - s0, 0);
      chk("clip_empty", int'(empty), 1);
`else
      chk("noclip_strobes", n_strobe - s0, 1);
      chk("noclip_x", int'(vga_x), 200);
`endif

      // print_enable already high when reset releases
      @(negedge clk);
      rst = 1'b1;
      pe = 1'b1;
      x = 8'd9; y = 7'd8; c = 3'd6;
      @(negedge clk);
      s0 = n_strobe;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      pe = 1'b0;
      repeat (3) @(negedge clk);
      chk("release_capture", n_strobe - s0, 1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) pe = ~pe;
         x = X_W'($urandom);
         y = Y_W'($urandom);
         c = C_W'($urandom);
      end

      // Bounded final drain
      pe = 1'b0;
      rdy = 1'b1;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (mq.size() == 0 && sb.size() == 0) ok = 1;
      end
      chk("final_drain_done", ok, 1);
      repeat (3) @(negedge clk);
      chk("final_empty", int'(empty), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
